// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer:
// state encoding, opcode/funct values, ALU codes and datapath mux selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_func_decode.sv
// R-type funct decoder: maps func to an ALU control code and flags whether
// the funct is one the datapath supports.
module alu_func_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] func,
  output logic [3:0] alu_cntl,
  output logic       valid
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    alu_cntl = ALU_AND;
    valid    = 1'b1;
    case (func)
      FN_ADD:  alu_cntl = ALU_ADD;
      FN_SUB:  alu_cntl = ALU_SUB;
      FN_AND:  alu_cntl = ALU_AND;
      FN_OR:   alu_cntl = ALU_OR;
      FN_SLT:  alu_cntl = ALU_SLT;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer with memory-handshake timeout.
// Define PERF_CNT_EN to build the retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        branch_ne,
  output logic [1:0]  pc_source,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_cntl,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic        mem_timeout,
  output logic [31:0] instr_retired
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]      func_alu;
  logic            func_ok;
  logic            waiting, limit, timeout;

  alu_func_decode u_func_decode (
    .func     (func),
    .alu_cntl (func_alu),
    .valid    (func_ok)
  );

  // Only an outstanding memory access can stall; everything else is one cycle.
  assign waiting = (state_q == FETCH && run) || state_q == MEMRD || state_q == MEMWR;
  assign limit   = (TIMEOUT_CYCLES > 0) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
  assign timeout = waiting && limit && !mem_ready;

  // The counter restarts whenever an access completes, aborts or is not pending.
  assign to_cnt_d = (!waiting || mem_ready || timeout || TIMEOUT_CYCLES == 0)
                    ? '0 : to_cnt_q + TO_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      to_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from pre-edge values.
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCSRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_cntl      = ALU_AND;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    // Held reset forces every control low, even the FETCH memory request.
    if (reset) begin
      case (state_q)
        FETCH: begin
          if (run) begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_cntl  = ALU_ADD;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              state_d  = DECODE;
            end else if (timeout) begin
              mem_timeout = 1'b1;
            end
          end
        end
        DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          alu_cntl  = ALU_ADD;
          case (op)
            OP_RTYPE: begin
              if (func_ok) state_d = EXEC;
              else begin
                illegal_op = 1'b1;
                state_d    = FETCH;
              end
            end
            OP_LW, OP_SW:   state_d = MEMADR;
            OP_BEQ, OP_BNE: state_d = BRANCH;
            OP_ADDI:        state_d = ADDIEX;
            OP_J:           state_d = JUMP;
            default: begin
              illegal_op = 1'b1;
              state_d    = FETCH;
            end
          endcase
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_cntl  = ALU_ADD;
          state_d   = (op == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_d = MEMWB;
          else if (timeout) begin
            mem_timeout = 1'b1;
            state_d     = FETCH;
          end
        end
        MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          state_d    = FETCH;
        end
        MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) state_d = FETCH;
          else if (timeout) begin
            mem_timeout = 1'b1;
            state_d     = FETCH;
          end
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_cntl  = func_alu;
          state_d   = ALUWB;
        end
        ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          state_d   = FETCH;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_cntl      = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          branch_ne     = (op == OP_BNE);
          state_d       = FETCH;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_cntl  = ALU_ADD;
          state_d   = ADDIWB;
        end
        ADDIWB: begin
          reg_write = 1'b1;
          state_d   = FETCH;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
          state_d   = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic        retire;
  logic [31:0] retired_q;

  // Completing states always return to FETCH; a store completes only on mem_ready.
  assign retire = (state_q inside {MEMWB, ALUWB, BRANCH, ADDIWB, JUMP})
                || (state_q == MEMWR && mem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign instr_retired = retired_q;
`else
  assign instr_retired = '0;
`endif

endmodule
